// File: rtl/mops_stim_engine_if.sv
// Hub-side handshake bundle between the MOPS stimulus engine and MOPSHUB.
// The master side is the engine: it issues requests/responses and observes hub frames.
interface mops_stim_engine_if;
    logic [75:0] data_tra_downlink;
    logic [4:0]  can_tra_select;
    logic        tra_valid;
    logic [75:0] data_rec_uplink;
    logic [4:0]  can_rec_select;
    logic        rec_valid;
    logic [75:0] req_frame;
    logic        req_valid;
    logic [75:0] rsp_frame;
    logic [4:0]  rsp_bus;
    logic        rsp_valid;

    modport master (
        input  data_tra_downlink, can_tra_select, tra_valid,
        input  data_rec_uplink, can_rec_select, rec_valid,
        output req_frame, req_valid, rsp_frame, rsp_bus, rsp_valid
    );

    modport slave (
        output data_tra_downlink, can_tra_select, tra_valid,
        output data_rec_uplink, can_rec_select, rec_valid,
        input  req_frame, req_valid, rsp_frame, rsp_bus, rsp_valid
    );
endinterface

// File: rtl/mops_stim_engine.sv
// MOPSHUB stimulus engine: emulates the elink master and a MOPS node across every
// bus/ADC channel, checks the hub's forwarded frames and counts errors.
module mops_stim_engine #(
    parameter int         MOPS_DIV = 4,
    parameter logic [6:0] NODE_ID  = 7'h01,
    parameter logic [4:0] CH_LAST  = 5'd31,
    parameter int         TIMEOUT  = 4096
) (
    input  logic               clk_40_m,
    input  logic               rst,
    input  logic [4:0]         i_n_buses,
    input  logic               i_start_data_gen,
    input  logic               i_ext_rst_mops,
    input  logic               i_test_rx,
    input  logic               i_test_tx,
    mops_stim_engine_if.master hub,
    output logic               o_clk_mops,
    output logic [7:0]         o_bus_id,
    output logic [4:0]         o_adc_ch,
    output logic [75:0]        o_bus_dec_data,
    output logic               o_test_rx_start,
    output logic               o_test_rx_end,
    output logic               o_test_tx_start,
    output logic               o_test_tx_end,
    output logic [15:0]        o_err_cnt
);

    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]    DIV_LAST = 16'(MOPS_DIV - 1);
    localparam logic [15:0]    DIV_HALF = 16'(MOPS_DIV / 2);
    localparam logic [10:0]    COB_REQ  = 11'h600 + {4'b0000, NODE_ID};
    localparam logic [10:0]    COB_RSP  = 11'h580 + {4'b0000, NODE_ID};

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_DN, S_RSP, S_WAIT_UP, S_NEXT, S_DONE
    } state_t;

    function automatic logic [75:0] f_reqFrame(input logic [4:0] ch);
        logic [7:0] idx;
        idx = {3'b000, ch} + 8'd1;
        return {1'b0, COB_REQ, 8'h40, 8'h00, 8'h24, idx, 32'h0};
    endfunction

    // Node response carries the ADC value V = {3'b0, bus, 3'b0, ch}, little-endian.
    function automatic logic [75:0] f_rspFrame(input logic [4:0] bus, input logic [4:0] ch);
        logic [7:0]  idx;
        logic [15:0] v;
        idx = {3'b000, ch} + 8'd1;
        v   = {3'b000, bus, 3'b000, ch};
        return {1'b0, COB_RSP, 8'h43, 8'h00, 8'h24, idx, v[7:0], v[15:8], 16'h0};
    endfunction

    logic [15:0]   r_divCnt;
    logic          r_clkMops;
    logic          r_armed;
    state_t        r_state, w_nextState;
    logic          r_modeRx, w_modeRxNext;
    logic [4:0]    r_busIdx, w_busIdxNext;
    logic [4:0]    r_adcCh, w_adcChNext;
    logic [TW-1:0] r_timer, w_timerNext;
    logic [15:0]   r_errCnt;
    logic [75:0]   r_reqFrame, r_rspFrame, r_busDecData;
    logic          r_reqValid, r_rspValid;
    logic [4:0]    r_rspBus;
    logic          r_rxStart, r_rxEnd, r_txStart, r_txEnd;
    logic          w_errInc, w_decLoad;
    logic [75:0]   w_decData;
    logic          w_rxStart, w_rxEnd, w_txStart, w_txEnd;
    logic          w_lastItem;

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_divCnt  <= '0;
            r_clkMops <= 1'b0;
        end else begin
            r_clkMops <= (r_divCnt >= DIV_HALF);
            r_divCnt  <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + 16'd1;
        end
    end

    assign w_lastItem = (r_busIdx == i_n_buses) && (r_adcCh == CH_LAST);

    always_comb begin
        w_nextState  = r_state;
        w_modeRxNext = r_modeRx;
        w_busIdxNext = r_busIdx;
        w_adcChNext  = r_adcCh;
        w_timerNext  = '0;
        w_errInc     = 1'b0;
        w_decLoad    = 1'b0;
        w_decData    = hub.data_tra_downlink;
        w_rxStart    = 1'b0;
        w_rxEnd      = 1'b0;
        w_txStart    = 1'b0;
        w_txEnd      = 1'b0;
        if (i_ext_rst_mops) begin
            w_nextState  = S_IDLE;
            w_busIdxNext = '0;
            w_adcChNext  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_armed && (i_test_rx || i_test_tx)) begin
                        w_modeRxNext = i_test_rx;
                        w_busIdxNext = '0;
                        w_adcChNext  = '0;
                        w_rxStart    = i_test_rx;
                        w_txStart    = !i_test_rx;
                        w_nextState  = i_test_rx ? S_RSP : S_REQ;
                    end
                end
                S_REQ:  w_nextState = S_WAIT_DN;
                S_WAIT_DN: begin
                    w_timerNext = r_timer + 1'b1;
                    if (hub.tra_valid && (hub.can_tra_select == r_busIdx)) begin
                        w_decLoad   = 1'b1;
                        w_errInc    = (hub.data_tra_downlink != f_reqFrame(r_adcCh));
                        w_nextState = S_RSP;
                    end else if (r_timer == TMO_LAST) begin
                        w_errInc    = 1'b1;
                        w_nextState = S_NEXT;
                    end
                end
                S_RSP:  w_nextState = S_WAIT_UP;
                S_WAIT_UP: begin
                    w_timerNext = r_timer + 1'b1;
                    w_decData   = hub.data_rec_uplink;
                    if (hub.rec_valid && (hub.can_rec_select == r_busIdx)) begin
                        w_decLoad   = 1'b1;
                        w_errInc    = (hub.data_rec_uplink != f_rspFrame(r_busIdx, r_adcCh));
                        w_nextState = S_NEXT;
                    end else if (r_timer == TMO_LAST) begin
                        w_errInc    = 1'b1;
                        w_nextState = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_lastItem) begin
                        w_nextState = S_DONE;
                    end else begin
                        if (r_adcCh < CH_LAST) begin
                            w_adcChNext = r_adcCh + 5'd1;
                        end else begin
                            w_adcChNext  = '0;
                            w_busIdxNext = r_busIdx + 5'd1;
                        end
                        w_nextState = r_modeRx ? S_RSP : S_REQ;
                    end
                end
                S_DONE: begin
                    w_rxEnd     = r_modeRx;
                    w_txEnd     = !r_modeRx;
                    w_nextState = S_IDLE;
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Request/response pulses and frames are registered off the next state so they
    // line up with the REQ/RSP state cycle itself.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_modeRx     <= 1'b0;
            r_busIdx     <= '0;
            r_adcCh      <= '0;
            r_timer      <= '0;
            r_errCnt     <= '0;
            r_reqFrame   <= '0;
            r_reqValid   <= 1'b0;
            r_rspFrame   <= '0;
            r_rspBus     <= '0;
            r_rspValid   <= 1'b0;
            r_busDecData <= '0;
            r_rxStart    <= 1'b0;
            r_rxEnd      <= 1'b0;
            r_txStart    <= 1'b0;
            r_txEnd      <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_modeRx   <= w_modeRxNext;
            r_busIdx   <= w_busIdxNext;
            r_adcCh    <= w_adcChNext;
            r_timer    <= w_timerNext;
            r_reqValid <= (w_nextState == S_REQ);
            r_rspValid <= (w_nextState == S_RSP);
            r_rxStart  <= w_rxStart;
            r_rxEnd    <= w_rxEnd;
            r_txStart  <= w_txStart;
            r_txEnd    <= w_txEnd;
            if (i_start_data_gen) r_armed <= 1'b1;
            if (w_nextState == S_REQ) r_reqFrame <= f_reqFrame(w_adcChNext);
            if (w_nextState == S_RSP) begin
                r_rspFrame <= f_rspFrame(w_busIdxNext, w_adcChNext);
                r_rspBus   <= w_busIdxNext;
            end
            if (w_decLoad) r_busDecData <= w_decData;
            if (w_errInc && (r_errCnt != 16'hFFFF)) r_errCnt <= r_errCnt + 16'd1;
        end
    end

    assign hub.req_frame    = r_reqFrame;
    assign hub.req_valid    = r_reqValid;
    assign hub.rsp_frame    = r_rspFrame;
    assign hub.rsp_bus      = r_rspBus;
    assign hub.rsp_valid    = r_rspValid;
    assign o_clk_mops       = r_clkMops;
    assign o_bus_id         = {3'b000, r_busIdx};
    assign o_adc_ch         = r_adcCh;
    assign o_bus_dec_data   = r_busDecData;
    assign o_test_rx_start  = r_rxStart;
    assign o_test_rx_end    = r_rxEnd;
    assign o_test_tx_start  = r_txStart;
    assign o_test_tx_end    = r_txEnd;
    assign o_err_cnt        = r_errCnt;

endmodule

// File: tb/tb_mops_stim_engine.sv
// Directed bench for mops_stim_engine: divider, RX/TX walks, wrong-bus, corruption,
// timeouts, abort and reset, with hand-computed expected frames and counts.
`timescale 1ns/1ps
module tb_mops_stim_engine;

    logic        clk_40_m = 1'b0;
    logic        rst;
    logic [4:0]  n_buses;
    logic        start_data_gen, ext_rst_mops, test_rx, test_tx;
    logic        o_clk_mops;
    logic [7:0]  o_bus_id;
    logic [4:0]  o_adc_ch;
    logic [75:0] o_bus_dec_data;
    logic        o_test_rx_start, o_test_rx_end, o_test_tx_start, o_test_tx_end;
    logic [15:0] o_err_cnt;

    int nCompared = 0;
    int nMismatched = 0;
    int cntReq = 0, cntRsp = 0, cntRxStart = 0, cntRxEnd = 0, cntTxStart = 0, cntTxEnd = 0;
    logic [75:0] capRsp13 = '0;
    logic [75:0] capReq5 = '0;

    always #5 clk_40_m = ~clk_40_m;

    mops_stim_engine_if hubIf();

    mops_stim_engine #(.MOPS_DIV(4), .NODE_ID(7'h01), .CH_LAST(5'd31), .TIMEOUT(16)) dut (
        .clk_40_m        (clk_40_m),
        .rst             (rst),
        .i_n_buses       (n_buses),
        .i_start_data_gen(start_data_gen),
        .i_ext_rst_mops  (ext_rst_mops),
        .i_test_rx       (test_rx),
        .i_test_tx       (test_tx),
        .hub             (hubIf),
        .o_clk_mops      (o_clk_mops),
        .o_bus_id        (o_bus_id),
        .o_adc_ch        (o_adc_ch),
        .o_bus_dec_data  (o_bus_dec_data),
        .o_test_rx_start (o_test_rx_start),
        .o_test_rx_end   (o_test_rx_end),
        .o_test_tx_start (o_test_tx_start),
        .o_test_tx_end   (o_test_tx_end),
        .o_err_cnt       (o_err_cnt)
    );

    // Pulse counters and frame captures used by the scenario tasks.
    always @(negedge clk_40_m) begin
        if (hubIf.req_valid === 1'b1) begin
            cntReq = cntReq + 1;
            if (o_adc_ch == 5'd5) capReq5 = hubIf.req_frame;
        end
        if (hubIf.rsp_valid === 1'b1) begin
            cntRsp = cntRsp + 1;
            if (o_bus_id == 8'd1 && o_adc_ch == 5'd3) capRsp13 = hubIf.rsp_frame;
        end
        if (o_test_rx_start === 1'b1) cntRxStart = cntRxStart + 1;
        if (o_test_rx_end === 1'b1)   cntRxEnd = cntRxEnd + 1;
        if (o_test_tx_start === 1'b1) cntTxStart = cntTxStart + 1;
        if (o_test_tx_end === 1'b1)   cntTxEnd = cntTxEnd + 1;
    end

    task automatic runSequence(input bit echoDn, input bit echoUp, input int maxCycles, output bit ended);
        bit          pendDn, pendUp;
        logic [75:0] dnFrame, upFrame;
        logic [4:0]  dnSel, upSel;
        ended = 1'b0; pendDn = 1'b0; pendUp = 1'b0;
        dnFrame = '0; upFrame = '0; dnSel = '0; upSel = '0;
        for (int i = 0; i < maxCycles && !ended; i++) begin
            @(negedge clk_40_m);
            hubIf.tra_valid = 1'b0;
            hubIf.rec_valid = 1'b0;
            if (pendDn) begin
                hubIf.tra_valid = 1'b1; hubIf.data_tra_downlink = dnFrame; hubIf.can_tra_select = dnSel;
                pendDn = 1'b0;
            end
            if (pendUp) begin
                hubIf.rec_valid = 1'b1; hubIf.data_rec_uplink = upFrame; hubIf.can_rec_select = upSel;
                pendUp = 1'b0;
            end
            if (echoDn && hubIf.req_valid === 1'b1) begin
                pendDn = 1'b1; dnFrame = hubIf.req_frame; dnSel = o_bus_id[4:0];
            end
            if (echoUp && hubIf.rsp_valid === 1'b1) begin
                pendUp = 1'b1; upFrame = hubIf.rsp_frame; upSel = hubIf.rsp_bus;
            end
            if (o_test_rx_end === 1'b1 || o_test_tx_end === 1'b1) begin
                ended = 1'b1; test_rx = 1'b0; test_tx = 1'b0;
            end
        end
        hubIf.tra_valid = 1'b0;
        hubIf.rec_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset(input string tag);
        rst = 1'b0; test_rx = 1'b0; test_tx = 1'b0; ext_rst_mops = 1'b0; start_data_gen = 1'b0;
        repeat (3) @(negedge clk_40_m);
        nCompared++;
        if ({o_clk_mops, hubIf.req_valid, hubIf.rsp_valid, o_test_rx_start, o_test_rx_end,
             o_test_tx_start, o_test_tx_end} !== 7'b0) begin
            nMismatched++;
            $display("[TB] FAIL %s_strobes: got %b expected 0", tag, {o_clk_mops, hubIf.req_valid,
                     hubIf.rsp_valid, o_test_rx_start, o_test_rx_end, o_test_tx_start, o_test_tx_end});
        end
        nCompared++;
        if ({hubIf.req_frame, hubIf.rsp_frame, o_bus_dec_data} !== 228'b0) begin
            nMismatched++;
            $display("[TB] FAIL %s_frames: got %h / %h / %h expected 0", tag, hubIf.req_frame,
                     hubIf.rsp_frame, o_bus_dec_data);
        end
        nCompared++;
        if ({hubIf.rsp_bus, o_bus_id, o_adc_ch, o_err_cnt} !== 34'b0) begin
            nMismatched++;
            $display("[TB] FAIL %s_counters: bus %h ch %h rsp_bus %h err %h expected 0", tag,
                     o_bus_id, o_adc_ch, hubIf.rsp_bus, o_err_cnt);
        end
    endtask

    task automatic test_divider();
        logic [7:0] expPat;
        expPat = 8'b1100_1100;
        @(negedge clk_40_m);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_40_m);
            #1;
            nCompared++;
            if (o_clk_mops !== expPat[k]) begin
                nMismatched++;
                $display("[TB] FAIL divider_edge%0d: got %b expected %b", k + 1, o_clk_mops, expPat[k]);
            end
        end
    endtask

    task automatic test_rx_happy();
        int  rsp0, req0, st0, en0;
        bit  ended;
        @(negedge clk_40_m);
        n_buses = 5'd1; start_data_gen = 1'b1;
        @(negedge clk_40_m);
        start_data_gen = 1'b0; test_rx = 1'b1;
        rsp0 = cntRsp; req0 = cntReq; st0 = cntRxStart; en0 = cntRxEnd;
        runSequence(1'b1, 1'b1, 1000, ended);
        nCompared++;
        if (!ended) begin nMismatched++; $display("[TB] FAIL rx_end_seen: got 0 expected 1"); end
        nCompared++;
        if (cntRsp - rsp0 != 64) begin
            nMismatched++; $display("[TB] FAIL rx_rsp_count: got %0d expected 64", cntRsp - rsp0);
        end
        nCompared++;
        if (cntReq - req0 != 0) begin
            nMismatched++; $display("[TB] FAIL rx_req_count: got %0d expected 0", cntReq - req0);
        end
        nCompared++;
        if (cntRxStart - st0 != 1 || cntRxEnd - en0 != 1) begin
            nMismatched++;
            $display("[TB] FAIL rx_pulses: got start %0d end %0d expected 1 1", cntRxStart - st0, cntRxEnd - en0);
        end
        nCompared++;
        if (capRsp13 !== 76'h581_4300_2404_0301_0000) begin
            nMismatched++; $display("[TB] FAIL rx_frame_b1c3: got %h expected %h", capRsp13, 76'h581_4300_2404_0301_0000);
        end
        nCompared++;
        if (o_err_cnt !== 16'd0) begin
            nMismatched++; $display("[TB] FAIL rx_err_cnt: got %0d expected 0", o_err_cnt);
        end
    endtask

    task automatic test_tx_happy();
        int  rsp0, req0, st0, en0;
        bit  ended;
        @(negedge clk_40_m);
        n_buses = 5'd0; test_tx = 1'b1;
        rsp0 = cntRsp; req0 = cntReq; st0 = cntTxStart; en0 = cntTxEnd;
        runSequence(1'b1, 1'b1, 1500, ended);
        nCompared++;
        if (!ended) begin nMismatched++; $display("[TB] FAIL tx_end_seen: got 0 expected 1"); end
        nCompared++;
        if (cntReq - req0 != 32 || cntRsp - rsp0 != 32) begin
            nMismatched++;
            $display("[TB] FAIL tx_items: got req %0d rsp %0d expected 32 32", cntReq - req0, cntRsp - rsp0);
        end
        nCompared++;
        if (cntTxStart - st0 != 1 || cntTxEnd - en0 != 1) begin
            nMismatched++;
            $display("[TB] FAIL tx_pulses: got start %0d end %0d expected 1 1", cntTxStart - st0, cntTxEnd - en0);
        end
        nCompared++;
        if (capReq5 !== 76'h601_4000_2406_0000_0000) begin
            nMismatched++; $display("[TB] FAIL tx_req_c5: got %h expected %h", capReq5, 76'h601_4000_2406_0000_0000);
        end
        nCompared++;
        if (o_bus_dec_data !== 76'h581_4300_2420_1F00_0000) begin
            nMismatched++;
            $display("[TB] FAIL tx_last_dec: got %h expected %h", o_bus_dec_data, 76'h581_4300_2420_1F00_0000);
        end
        nCompared++;
        if (o_err_cnt !== 16'd0) begin
            nMismatched++; $display("[TB] FAIL tx_err_cnt: got %0d expected 0", o_err_cnt);
        end
    endtask

    task automatic test_wrong_bus_corrupt();
        @(negedge clk_40_m);
        n_buses = 5'd0; test_tx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_40_m);
            if (hubIf.req_valid === 1'b1) break;
        end
        nCompared++;
        if (hubIf.req_frame !== 76'h601_4000_2401_0000_0000 || hubIf.req_valid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL wb_req_c0: got %h valid %b expected %h 1", hubIf.req_frame, hubIf.req_valid,
                     76'h601_4000_2401_0000_0000);
        end
        @(negedge clk_40_m);
        hubIf.tra_valid = 1'b1; hubIf.data_tra_downlink = 76'h601_4000_2401_0000_0000; hubIf.can_tra_select = 5'd1;
        @(negedge clk_40_m);
        nCompared++;
        if (hubIf.rsp_valid !== 1'b0 || o_bus_dec_data !== 76'h581_4300_2420_1F00_0000) begin
            nMismatched++;
            $display("[TB] FAIL wb_ignored: got rsp_valid %b dec %h expected 0 %h", hubIf.rsp_valid,
                     o_bus_dec_data, 76'h581_4300_2420_1F00_0000);
        end
        hubIf.can_tra_select = 5'd0;
        @(negedge clk_40_m);
        hubIf.tra_valid = 1'b0;
        nCompared++;
        if (hubIf.rsp_valid !== 1'b1 || o_bus_dec_data !== 76'h601_4000_2401_0000_0000 || o_err_cnt !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL wb_accept: got rsp_valid %b dec %h err %0d expected 1 %h 0", hubIf.rsp_valid,
                     o_bus_dec_data, o_err_cnt, 76'h601_4000_2401_0000_0000);
        end
        @(negedge clk_40_m);
        hubIf.rec_valid = 1'b1; hubIf.data_rec_uplink = 76'h581_4300_2401_FF00_0000; hubIf.can_rec_select = 5'd0;
        @(negedge clk_40_m);
        hubIf.rec_valid = 1'b0;
        nCompared++;
        if (o_err_cnt !== 16'd1 || o_bus_dec_data !== 76'h581_4300_2401_FF00_0000) begin
            nMismatched++;
            $display("[TB] FAIL corrupt_up: got err %0d dec %h expected 1 %h", o_err_cnt, o_bus_dec_data,
                     76'h581_4300_2401_FF00_0000);
        end
    endtask

    task automatic test_abort();
        int en0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_40_m);
            if (hubIf.req_valid === 1'b1) break;
        end
        nCompared++;
        if (hubIf.req_frame !== 76'h601_4000_2402_0000_0000 || o_adc_ch !== 5'd1) begin
            nMismatched++;
            $display("[TB] FAIL abort_req_c1: got %h ch %0d expected %h 1", hubIf.req_frame, o_adc_ch,
                     76'h601_4000_2402_0000_0000);
        end
        @(negedge clk_40_m);
        hubIf.tra_valid = 1'b1; hubIf.data_tra_downlink = 76'h601_4000_2402_0000_0000; hubIf.can_tra_select = 5'd0;
        @(negedge clk_40_m);
        hubIf.tra_valid = 1'b0;
        en0 = cntTxEnd;
        @(negedge clk_40_m);
        ext_rst_mops = 1'b1;
        @(negedge clk_40_m);
        ext_rst_mops = 1'b0; test_tx = 1'b0;
        nCompared++;
        if (o_adc_ch !== 5'd0 || hubIf.rsp_valid !== 1'b0 || hubIf.req_valid !== 1'b0 || o_err_cnt !== 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL abort_idle: got ch %0d rsp %b req %b err %0d expected 0 0 0 1", o_adc_ch,
                     hubIf.rsp_valid, hubIf.req_valid, o_err_cnt);
        end
        repeat (40) @(negedge clk_40_m);
        #1;
        nCompared++;
        if (cntTxEnd != en0 || o_err_cnt !== 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL abort_no_end: got end %0d err %0d expected 0 1", cntTxEnd - en0, o_err_cnt);
        end
    endtask

    task automatic test_timeout();
        bit ended;
        @(negedge clk_40_m);
        n_buses = 5'd0; test_rx = 1'b1;
        runSequence(1'b0, 1'b0, 3000, ended);
        nCompared++;
        if (!ended || o_err_cnt !== 16'd33) begin
            nMismatched++; $display("[TB] FAIL rx_timeout: got ended %b err %0d expected 1 33", ended, o_err_cnt);
        end
        @(negedge clk_40_m);
        test_tx = 1'b1;
        runSequence(1'b1, 1'b0, 4000, ended);
        nCompared++;
        if (!ended || o_err_cnt !== 16'd65) begin
            nMismatched++; $display("[TB] FAIL tx_up_timeout: got ended %b err %0d expected 1 65", ended, o_err_cnt);
        end
        nCompared++;
        if (o_bus_dec_data !== 76'h601_4000_2420_0000_0000) begin
            nMismatched++;
            $display("[TB] FAIL tx_timeout_dec: got %h expected %h", o_bus_dec_data, 76'h601_4000_2420_0000_0000);
        end
    endtask

    task automatic test_reset_disarms();
        int st0;
        @(negedge clk_40_m);
        rst = 1'b1; test_rx = 1'b1;
        st0 = cntRxStart;
        repeat (10) @(negedge clk_40_m);
        #1;
        nCompared++;
        if (cntRxStart != st0 || hubIf.rsp_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_disarm: got starts %0d rsp %b expected 0 0", cntRxStart - st0, hubIf.rsp_valid);
        end
        test_rx = 1'b0;
    endtask

    initial begin
        rst = 1'b0; n_buses = 5'd0; start_data_gen = 1'b0; ext_rst_mops = 1'b0;
        test_rx = 1'b0; test_tx = 1'b0;
        hubIf.tra_valid = 1'b0; hubIf.data_tra_downlink = '0; hubIf.can_tra_select = '0;
        hubIf.rec_valid = 1'b0; hubIf.data_rec_uplink = '0; hubIf.can_rec_select = '0;
        test_reset("reset");
        test_divider();
        test_rx_happy();
        test_tx_happy();
        test_wrong_bus_corrupt();
        test_abort();
        test_timeout();
        test_reset("final_reset");
        test_reset_disarms();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
